// File: rtl/dpr_pkg.sv
// Shared types and constants for the simple dual-port RAM.
// Read latency follows the DPR_OUT_REG_EN build macro.
package dpr_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StReady = 1'b1
  } dpr_state_e;

  localparam int unsigned DefaultDepth   = 64;
  localparam int unsigned DefaultClrLast = DefaultDepth - 1;

  // Last address the clear sequencer touches before handing over to users.
  function automatic int unsigned clr_last(input int unsigned depth);
    return depth - 1;
  endfunction

`ifdef DPR_OUT_REG_EN
  localparam int unsigned RdLatency = 2;
`else
  localparam int unsigned RdLatency = 1;
`endif

endpackage

// File: rtl/dpr_if.sv
// Request/response bundle for the dual-port RAM; the requester uses master, the RAM uses slave.
interface dpr_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ADDR  = 6
);

  logic             cs;
  logic             wr_en;
  logic [ADDR-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [ADDR-1:0]  rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             busy;
  logic             acc_err;

  modport master (
    output cs, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, acc_err
  );

  modport slave (
    input  cs, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, busy, acc_err
  );

endinterface

// File: rtl/dpr_clear_ctrl.sv
// Post-reset clear sequencer: walks every address writing zero, then releases the array.
module dpr_clear_ctrl
  import dpr_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned ADDR  = 6
) (
  input  logic            clk,
  input  logic            rst,
  output logic            busy,
  output logic            clr_we,
  output logic [ADDR-1:0] clr_addr
);

  localparam logic [ADDR-1:0] ClrLast = ADDR'(clr_last(DEPTH));

  dpr_state_e      state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b1;
    clr_we  = 1'b0;
    case (state_q)
      StClear: begin
        clr_we = 1'b1;
        if (cnt_q == ClrLast) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        busy = 1'b0;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM with write-first bypass and a post-reset clear sequence.
// Define DPR_OUT_REG_EN to add a second read output register stage.
module dual_port_ram
  import dpr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned ADDR  = 6
) (
  input logic   clk,
  input logic   rst,
  dpr_if.slave  bus
);

  logic             busy;
  logic             clr_we;
  logic [ADDR-1:0]  clr_addr;

  dpr_clear_ctrl #(
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic wr_req, rd_req, wr_in_range, rd_in_range, wr_ok, rd_ok, err_d, bypass;

  assign wr_req      = bus.cs & bus.wr_en;
  assign rd_req      = bus.cs & bus.rd_en;
  assign wr_in_range = 32'(bus.wr_addr) < DEPTH;
  assign rd_in_range = 32'(bus.rd_addr) < DEPTH;
  assign wr_ok       = wr_req & ~busy & wr_in_range;
  assign rd_ok       = rd_req & ~busy & rd_in_range;
  // Each port is judged on its own; a bad port does not block a legal one.
  assign err_d       = (wr_req | rd_req) &
                       (busy | (wr_req & ~wr_in_range) | (rd_req & ~rd_in_range));
  assign bypass      = wr_ok & (bus.wr_addr == bus.rd_addr);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  // Clear owns the write port while it runs.
  always_comb begin
    mem_we    = clr_we | wr_ok;
    mem_addr  = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (clr_we) begin
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             acc_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      acc_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      acc_err_q  <= err_d;
      if (rd_ok) begin
        rd_data_q <= bypass ? bus.wr_data : mem[bus.rd_addr];
      end
    end
  end

`ifdef DPR_OUT_REG_EN
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= rd_data_q;
      out_valid_q <= rd_valid_q;
    end
  end

  assign bus.rd_data  = out_data_q;
  assign bus.rd_valid = out_valid_q;
`else
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.busy    = busy;
  assign bus.acc_err = acc_err_q;

endmodule
